// File: rtl/boa_irq_ctl.sv
// External interrupt controller: synchronises, latches, masks and prioritises
// interrupt lines into one registered irq, with claim/complete by source ID.
module boa_irq_ctl #(
  parameter logic [31:0] addr  = 32'hffff_f100,
  parameter int unsigned n_src = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [n_src-1:0] src,
  input  logic [31:0]      bus_addr,
  input  logic             bus_re,
  input  logic [3:0]       bus_we,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ready,
  output logic             irq
);

  // Implemented source bits: 1 .. n_src-1
  localparam logic [31:0] VMASK = 32'((64'd1 << n_src) - 64'd1) & 32'hffff_fffe;

  typedef enum logic [1:0] {
    REG_PEND   = 2'd0,
    REG_ENABLE = 2'd1,
    REG_EDGE   = 2'd2,
    REG_CLAIM  = 2'd3
  } reg_sel_e;

  logic [31:0] sync1, sync_s, prev_p;
  logic [31:0] pend_e, enable, edge_mode, in_svc;

  logic [31:0] src_w, off, pend_view, eligible;
  logic [31:0] claim_mask, cmpl_mask, w1c_mask, chg_mask, set_mask, rd_val;
  logic        hit, wr_full, claim_rd;
  reg_sel_e    sel;
  logic [4:0]  winner;

  assign bus_ready = 1'b1;

  always_comb begin
    src_w = '0;
    src_w[n_src-1:0] = src;
    src_w = src_w & VMASK;

    off     = bus_addr - addr;
    hit     = (off[31:4] == '0) && (off[1:0] == 2'b00);
    sel     = reg_sel_e'(off[3:2]);
    wr_full = hit && (bus_we == 4'hf);

    // Level sources report the detect-stage level so both modes share one latency
    pend_view = ((pend_e & edge_mode) | (prev_p & ~edge_mode)) & VMASK;
    eligible  = pend_view & enable & ~in_svc;

    winner = '0;
    for (int unsigned i = 31; i >= 1; i--) begin
      if (eligible[i]) winner = 5'(i);
    end

    claim_rd   = bus_re && hit && (sel == REG_CLAIM) && (winner != 5'd0);
    claim_mask = claim_rd ? (32'd1 << winner) : '0;

    cmpl_mask = '0;
    if (wr_full && (sel == REG_CLAIM) && (bus_wdata[4:0] != 5'd0) &&
        (32'(bus_wdata[4:0]) < n_src))
      cmpl_mask = (32'd1 << bus_wdata[4:0]) & VMASK;

    w1c_mask = (wr_full && (sel == REG_PEND)) ? (bus_wdata & edge_mode & VMASK) : '0;
    chg_mask = (wr_full && (sel == REG_EDGE)) ? ((bus_wdata & VMASK) ^ edge_mode) : '0;
    set_mask = sync_s & ~prev_p & edge_mode;

    rd_val = '0;
    if (bus_re && hit) begin
      case (sel)
        REG_PEND:   rd_val = pend_view;
        REG_ENABLE: rd_val = enable;
        REG_EDGE:   rd_val = edge_mode;
        REG_CLAIM:  rd_val = 32'(winner);
        default:    rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync_s    <= '0;
      prev_p    <= '0;
      pend_e    <= '0;
      enable    <= '0;
      edge_mode <= '0;
      in_svc    <= '0;
      irq       <= 1'b0;
      bus_rdata <= '0;
    end else begin
      sync1  <= src_w;
      sync_s <= sync1;
      prev_p <= sync_s;
      // New edge beats W1C/claim clear; a mode switch discards the stored edge
      pend_e <= ((pend_e & ~(w1c_mask | claim_mask)) | set_mask) & ~chg_mask;
      if (wr_full && (sel == REG_ENABLE)) enable <= bus_wdata & VMASK;
      if (wr_full && (sel == REG_EDGE)) edge_mode <= bus_wdata & VMASK;
      // Claim is judged on pre-complete state, so the two masks never collide
      in_svc    <= (in_svc & ~cmpl_mask) | claim_mask;
      irq       <= |eligible;
      bus_rdata <= rd_val;
    end
  end

endmodule

// File: doc/boa_irq_ctl.md
Name: boa_irq_ctl

Overview:
- Memory-mapped external interrupt controller on the CPU data bus.
- Gathers the machine-timer interrupt line (source 1) and up to n_src-2 further external lines.
- Latches, masks and prioritises them into a single irq output for the core's machine external interrupt input.
- Software claims the winning source by ID and completes it with a register write.

Parameters:
- addr, 32'hffff_f100: word-aligned base address; four 32-bit registers at addr+0 .. addr+12.
- n_src, 32: number of sources including reserved ID 0; legal range 2..32.

Ports:
- clk  input  1  CPU clock
- rst  input  1  asynchronous, active-high reset
- src  input  n_src  interrupt lines; bit 0 ignored; may be asynchronous to clk
- bus_addr  input  32  byte address
- bus_re  input  1  read strobe
- bus_we  input  4  byte write enables; only 4'hf performs a write
- bus_wdata  input  32  write data
- bus_rdata  output  32  read data, registered
- bus_ready  output  1  access complete
- irq  output  1  interrupt request to core, registered

Behaviour:
- Reset, asynchronous on rst rising, held while rst=1:
  - bus_rdata=0, bus_ready=1, irq=0
  - all pending, enable, edge-mode and in-service bits = 0
  - synchroniser flops = 0
- Input conditioning: each src[i], i≥1, passes through a 2-flop synchroniser (s), then a previous-value flop (p) for edge detection.
- Register map (word offsets):
  - +0 PENDING
  - +4 ENABLE (RW)
  - +8 EDGE (RW; 1 = rising-edge source, 0 = level source)
  - +C CLAIM
  - Bits ≥ n_src and bit 0 read 0 and ignore writes.
- Pending, edge sources: bit set when s & ~p. Bit cleared by:
  - a write of 1 to that PENDING bit (write-1-clear), or
  - a claim of that ID.
  - If set and clear happen in the same cycle, set wins.
- Pending, level sources: PENDING reads the live synchronised level. Writes to these bits are ignored.
- Switching a bit in EDGE clears its stored edge-pending bit.
- Eligible set = pending & enable & ~in_service.
- irq is registered: irq ← |eligible. Latency from src edge to irq = 4 clk (2 sync + detect + irq register).
- Winner = lowest-numbered eligible ID; 0 if none.
- CLAIM read (bus_re with CLAIM address):
  - rdata ← winner.
  - If winner≠0: in_service[winner] ← 1. If the winner is an edge source, its pending bit clears in the same cycle.
- CLAIM write (we=4'hf), wdata[4:0]=k, 1≤k<n_src: in_service[k] ← 0.
  - Writes of 0, of an ID ≥ n_src, or of an ID not in service have no effect.
- A write and a read to the same address in one cycle: the read returns the pre-write value.
  - Simultaneous CLAIM read and CLAIM write: the complete is applied first, then the claim is evaluated on pre-complete state.
- Bus timing:
  - Every access completes in one cycle; bus_ready stays 1 after reset.
  - bus_rdata is valid the cycle after the strobe.
  - bus_rdata = 0 for unmapped addresses or when bus_re=0.
  - Partial writes (we≠0, ≠4'hf) are ignored.
- A source already in service cannot raise irq again until completed.
  - An edge pulse arriving while in service is still latched into PENDING.
- rst asserted mid-claim: all state returns to reset values immediately; no claim side-effect survives.

Test Plan:
- Reset, then read all four registers -> rdata 0 each; irq=0; ready=1 throughout.
- ENABLE=32'h2, EDGE=0, raise src[1] level -> irq=1 exactly 4 clk later; CLAIM read returns 1; irq drops next cycle. Write CLAIM=1 with src[1] still high -> irq=1 again one cycle after the write.
- EDGE=32'h0C, ENABLE=32'h0C, pulse src[3] then src[2] for 1 clk each -> PENDING=32'h0C. First claim returns 2, second returns 3, third returns 0. PENDING=0 after both claims.
- Edge source 5 pending but ENABLE bit 5=0 -> irq stays 0. Write PENDING=32'h20 -> PENDING reads 0. Enable bit 5 afterwards -> irq stays 0.
- Edge detected on src[4] in the same cycle as a W1C write of bit 4 -> PENDING bit 4 reads 1.
- Assert rst while in_service=32'h2 and PENDING=32'h8 -> all registers read 0 and irq=0 within the cycle rst is sampled high, with no clock required.
